// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg.sv - shared types and helpers for the power-switch sequencer
package gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_SETTLE,
        ST_ON,
        ST_RAMP_DOWN
    } pwrsw_state_e;

    // Step counter only needs to reach STEP_CYC-1; keep at least one bit.
    function automatic int step_cnt_w(input int step_cyc);
        return (step_cyc <= 2) ? 1 : $clog2(step_cyc);
    endfunction

    function automatic int settle_cnt_w(input int settle_cyc);
        return $clog2(settle_cyc + 1);
    endfunction

    function automatic bit params_legal(input int nseg, input int step_cyc, input int settle_cyc);
        return (nseg >= 1) && (step_cyc >= 1) && (settle_cyc >= 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_tc_cnt.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_tc_cnt.sv - up-counter with clear, enable and terminal-count flag
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_tc_cnt #(
    parameter int W  = 1,
    parameter int TC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TC_V = W'(TC);

    logic [W-1:0] cnt;

    // Wraps to zero on the terminal count so back-to-back periods need no clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

    assign tc = (cnt == TC_V);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv - staggered power-switch segment enable sequencer
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq
    import gf180mcu_fd_sc_mcu9t5v0__pwrsw_pkg::*;
#(
    parameter int NSEG       = 8,
    parameter int STEP_CYC   = 4,
    parameter int SETTLE_CYC = 16
) (
`ifdef USE_POWER_PINS
    inout  wire             VDD,
    inout  wire             VSS,
`endif
    input  logic            CLK,
    input  logic            RST,
    input  logic            PWR_REQ,
    input  logic            FORCE_OFF,
    output logic [NSEG-1:0] SEG_EN,
    output logic            PWR_ACK,
    output logic            BUSY
);

    if (!params_legal(NSEG, STEP_CYC, SETTLE_CYC)) begin : g_bad_params
        $error("pwrsw_seq: NSEG, STEP_CYC and SETTLE_CYC must all be >= 1");
    end

    localparam int STEP_W   = step_cnt_w(STEP_CYC);
    localparam int SETTLE_W = settle_cnt_w(SETTLE_CYC);

    pwrsw_state_e    state_q, state_d;
    logic [NSEG-1:0] seg_q, seg_d, seg_dn, seg_up;
    logic            ack_q, ack_d;
    logic            step_tc, settle_tc;
    logic            step_en, settle_en, cnt_clr;
    pwrsw_state_e    down_state;

    assign seg_dn     = seg_q >> 1;
    assign seg_up     = (seg_q << 1) | NSEG'(1);
    assign down_state = (seg_dn == '0) ? ST_OFF : ST_RAMP_DOWN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_OFF;
            seg_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        if (FORCE_OFF) begin
            state_d = ST_OFF;
            seg_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (PWR_REQ) begin
                        seg_d   = NSEG'(1);
                        state_d = (NSEG == 1) ? ST_SETTLE : ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (!PWR_REQ) begin
                        seg_d   = seg_dn;
                        state_d = down_state;
                    end else if (step_tc) begin
                        seg_d   = seg_up;
                        state_d = seg_up[NSEG-1] ? ST_SETTLE : ST_RAMP_UP;
                    end
                end
                ST_SETTLE: begin
                    if (!PWR_REQ) begin
                        seg_d   = seg_dn;
                        state_d = down_state;
                    end else if (settle_tc) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!PWR_REQ) begin
                        seg_d   = seg_dn;
                        state_d = down_state;
                    end
                end
                // Requests are ignored until the ramp-down has fully completed.
                ST_RAMP_DOWN: begin
                    if (step_tc) begin
                        seg_d   = seg_dn;
                        state_d = down_state;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    seg_d   = '0;
                end
            endcase
        end
    end

    assign ack_d     = (state_d == ST_ON);
    assign cnt_clr   = FORCE_OFF || (state_d != state_q);
    assign step_en   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign settle_en = (state_q == ST_SETTLE);

    gf180mcu_fd_sc_mcu9t5v0__pwrsw_tc_cnt #(
        .W  (STEP_W),
        .TC (STEP_CYC - 1)
    ) u_step_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (cnt_clr),
        .en  (step_en),
        .tc  (step_tc)
    );

    gf180mcu_fd_sc_mcu9t5v0__pwrsw_tc_cnt #(
        .W  (SETTLE_W),
        .TC (SETTLE_CYC - 1)
    ) u_settle_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (cnt_clr),
        .en  (settle_en),
        .tc  (settle_tc)
    );

    assign SEG_EN  = seg_q;
    assign PWR_ACK = ack_q;
    assign BUSY    = (state_q == ST_RAMP_UP) || (state_q == ST_SETTLE) || (state_q == ST_RAMP_DOWN);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv - directed bench for the power-switch sequencer
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq;

    logic       CLK;
    logic       RST;
    logic       PWR_REQ;
    logic       FORCE_OFF;
    logic [7:0] SEG_EN;
    logic       PWR_ACK;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         ph;
        int         at;
        logic [7:0] seg;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .PWR_REQ   (PWR_REQ),
        .FORCE_OFF (FORCE_OFF),
        .SEG_EN    (SEG_EN),
        .PWR_ACK   (PWR_ACK),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void add(input int ph, input int at, input logic [7:0] seg,
                                input logic ack, input logic busy);
        vec_t v;
        v.ph = ph; v.at = at; v.seg = seg; v.ack = ack; v.busy = busy;
        tbl.push_back(v);
    endfunction

    task automatic check_outs(input string name, input logic [7:0] seg, input logic ack,
                              input logic busy);
        checks++;
        if (SEG_EN !== seg) begin
            errors++;
            $display("FAIL %s seg_en: got %02h expected %02h", name, SEG_EN, seg);
        end
        checks++;
        if (PWR_ACK !== ack) begin
            errors++;
            $display("FAIL %s pwr_ack: got %b expected %b", name, PWR_ACK, ack);
        end
        checks++;
        if (BUSY !== busy) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", name, BUSY, busy);
        end
    endtask

    // Drives one edge per iteration (inputs set at negedge) and checks table rows after each edge.
    task automatic run_phase(input int ph, input int ncyc, input int chg_at,
                             input logic r0, input logic r1, input int force_at);
        for (int e = 0; e < ncyc; e++) begin
            PWR_REQ   = (e < chg_at) ? r0 : r1;
            FORCE_OFF = (e == force_at);
            @(posedge CLK);
            @(negedge CLK);
            foreach (tbl[i]) begin
                if (tbl[i].ph == ph && tbl[i].at == e)
                    check_outs($sformatf("ph%0d_edge%0d", ph, e), tbl[i].seg, tbl[i].ack, tbl[i].busy);
            end
        end
        FORCE_OFF = 1'b0;
    endtask

    initial begin
        // phase 0: turn-on from OFF
        add(0, 0, 8'h01, 0, 1); add(0, 3, 8'h01, 0, 1); add(0, 4, 8'h03, 0, 1);
        add(0, 8, 8'h07, 0, 1); add(0, 24, 8'h7F, 0, 1); add(0, 28, 8'hFF, 0, 1);
        add(0, 43, 8'hFF, 0, 1); add(0, 44, 8'hFF, 1, 0);
        // phase 1: turn-off from ON
        add(1, 0, 8'h7F, 0, 1); add(1, 4, 8'h3F, 0, 1); add(1, 24, 8'h01, 0, 1);
        add(1, 27, 8'h01, 0, 1); add(1, 28, 8'h00, 0, 0);
        // phase 2: abort during ramp-up at edge 9
        add(2, 8, 8'h07, 0, 1); add(2, 9, 8'h03, 0, 1); add(2, 12, 8'h03, 0, 1);
        add(2, 13, 8'h01, 0, 1); add(2, 17, 8'h00, 0, 0); add(2, 18, 8'h00, 0, 0);
        // phase 3: request re-raised during ramp-down
        add(3, 0, 8'h7F, 0, 1); add(3, 12, 8'h0F, 0, 1); add(3, 27, 8'h01, 0, 1);
        add(3, 28, 8'h00, 0, 0); add(3, 29, 8'h01, 0, 1); add(3, 33, 8'h03, 0, 1);
        // phase 4: force-off pulse in SETTLE, then full restart
        add(4, 0, 8'h01, 0, 1); add(4, 28, 8'hFF, 0, 1); add(4, 29, 8'hFF, 0, 1);
        add(4, 30, 8'h00, 0, 0); add(4, 31, 8'h01, 0, 1); add(4, 59, 8'hFF, 0, 1);
        add(4, 74, 8'hFF, 0, 1); add(4, 75, 8'hFF, 1, 0);
        // phase 5: force-off pulse in ON, then full restart
        add(5, 1, 8'hFF, 1, 0); add(5, 2, 8'h00, 0, 0); add(5, 3, 8'h01, 0, 1);
        add(5, 7, 8'h03, 0, 1); add(5, 46, 8'hFF, 0, 1); add(5, 47, 8'hFF, 1, 0);

        RST = 1'b1; PWR_REQ = 1'b0; FORCE_OFF = 1'b0;
        repeat (2) @(negedge CLK);
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        RST = 1'b0;

        run_phase(0, 45, 45, 1'b1, 1'b1, -1);
        run_phase(1, 29, 0, 1'b0, 1'b0, -1);
        run_phase(2, 19, 9, 1'b1, 1'b0, -1);
        run_phase(0, 45, 45, 1'b1, 1'b1, -1);
        run_phase(3, 34, 1, 1'b0, 1'b1, -1);

        // Asynchronous reset mid ramp-up: outputs must clear between clock edges.
        #2 RST = 1'b1;
        #1 check_outs("async_reset", 8'h00, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        run_phase(4, 76, 76, 1'b1, 1'b1, 30);
        run_phase(5, 48, 48, 1'b1, 1'b1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
